// File: rtl/riscv_pipeline_core_pkg.sv
// Shared types for the five-stage RV32I subset pipeline: opcodes, control bundle,
// pipeline-register layouts and the decode/immediate helpers used in ID.
package riscv_pkg;

   localparam int ROM_DEPTH  = 256;
   localparam int DMEM_DEPTH = 256;
   localparam int ROM_AW     = $clog2(ROM_DEPTH);
   localparam int DMEM_AW    = $clog2(DMEM_DEPTH);

   localparam logic [6:0] OP_IMM = 7'h13;
   localparam logic [6:0] OP     = 7'h33;
   localparam logic [6:0] LOAD   = 7'h03;
   localparam logic [6:0] STORE  = 7'h23;
   localparam logic [6:0] BRANCH = 7'h63;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {ALU_NONE, ALU_ADD} aluOp_e;

   typedef struct packed {
      logic regWrite;
      logic memRead;
      logic memWrite;
      logic branch;
      logic aluSrc;
      logic memToReg;
   } ctrl_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } ifId_t;

   typedef struct packed {
      ctrl_t       ctrl;
      aluOp_e      aluOp;
      logic [31:0] pc;
      logic [31:0] rs1Val;
      logic [31:0] rs2Val;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } idEx_t;

   typedef struct packed {
      logic        regWrite;
      logic        memWrite;
      logic        memToReg;
      logic [31:0] aluResult;
      logic [31:0] storeData;
      logic [4:0]  rd;
   } exMem_t;

   typedef struct packed {
      logic        regWrite;
      logic        memToReg;
      logic [31:0] aluResult;
      logic [31:0] loadData;
      logic [4:0]  rd;
   } memWb_t;

   // Any encoding outside the supported subset decodes to all-zero control (a NOP).
   function automatic ctrl_t decodeCtrl(input logic [31:0] instr);
      ctrl_t c;
      c = '0;
      if (instr[6:0] == OP_IMM && instr[14:12] == 3'd0) begin
         c.regWrite = 1'b1;
         c.aluSrc   = 1'b1;
      end else if (instr[6:0] == OP && instr[14:12] == 3'd0 && instr[31:25] == 7'd0) begin
         c.regWrite = 1'b1;
      end else if (instr[6:0] == LOAD && instr[14:12] == 3'd2) begin
         c.regWrite = 1'b1;
         c.memRead  = 1'b1;
         c.aluSrc   = 1'b1;
         c.memToReg = 1'b1;
      end else if (instr[6:0] == STORE && instr[14:12] == 3'd2) begin
         c.memWrite = 1'b1;
         c.aluSrc   = 1'b1;
      end else if (instr[6:0] == BRANCH && instr[14:12] == 3'd0) begin
         c.branch = 1'b1;
      end
      return c;
   endfunction

   function automatic logic [31:0] immGen(input logic [31:0] instr);
      logic [31:0] imm;
      case (instr[6:0])
         STORE:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         BRANCH:  imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         default: imm = {{20{instr[31]}}, instr[31:20]};
      endcase
      return imm;
   endfunction

endpackage

// File: rtl/riscv_pipeline_core_if.sv
// Word-addressed data-memory bus between the MEM stage and the data RAM.
interface riscv_pipeline_core_if;
   import riscv_pkg::*;

   logic [DMEM_AW-1:0] wordAddr;
   logic [31:0]        wdata;
   logic [31:0]        rdata;
   logic               we;

   modport master (output wordAddr, output wdata, output we, input rdata);
   modport slave  (input wordAddr, input wdata, input we, output rdata);

endinterface

// File: rtl/riscv_dmem.sv
// Word-addressed data RAM: synchronous write, combinational read, contents not reset.
module riscv_dmem
   import riscv_pkg::*;
(
   input logic                  clk,
   riscv_pipeline_core_if.slave bus
);

   logic [31:0] ram [0:DMEM_DEPTH-1];

   always_ff @(posedge clk) begin
      if (bus.we) begin
         ram[bus.wordAddr] <= bus.wdata;
      end
   end

   assign bus.rdata = ram[bus.wordAddr];

endmodule

// File: rtl/riscv_regfile.sv
// 32 x 32 register file, two read ports and one write port with write-to-read bypass.
module riscv_regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  raddrA_i,
   input  logic [4:0]  raddrB_i,
   output logic [31:0] rdataA_o,
   output logic [31:0] rdataB_o,
   input  logic        we_i,
   input  logic [4:0]  waddr_i,
   input  logic [31:0] wdata_i
);

   logic [31:0] regs [0:31];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            regs[i] <= '0;
         end
      end else if (we_i && waddr_i != 5'd0) begin
         regs[waddr_i] <= wdata_i;
      end
   end

   // A read of the register being written this cycle sees the new value.
   always_comb begin
      rdataA_o = regs[raddrA_i];
      rdataB_o = regs[raddrB_i];
      if (raddrA_i == 5'd0) begin
         rdataA_o = '0;
      end else if (we_i && waddr_i == raddrA_i) begin
         rdataA_o = wdata_i;
      end
      if (raddrB_i == 5'd0) begin
         rdataB_o = '0;
      end else if (we_i && waddr_i == raddrB_i) begin
         rdataB_o = wdata_i;
      end
   end

endmodule

// File: rtl/riscv_pipeline_core.sv
// Five-stage in-order RV32I subset core (ADDI/ADD/LW/SW/BEQ) with internal ROM,
// register file and data RAM; hazard detection and forwarding live here.
module riscv_pipeline_core
   import riscv_pkg::*;
(
   input logic clk,
   input logic rst
);

   logic [31:0] rom [0:ROM_DEPTH-1];

   riscv_pipeline_core_if dmemBus ();

   logic [31:0] pc_q, pc_d;
   ifId_t       ifId_q, ifId_d;
   idEx_t       idEx_q, idEx_d;
   exMem_t      exMem_q, exMem_d;
   memWb_t      memWb_q, memWb_d;

   ctrl_t       idCtrl;
   logic [4:0]  idRs1, idRs2;
   logic [31:0] rs1Val, rs2Val;
   logic [31:0] wbValue, fwdA, fwdB, aluB, aluResult;
   logic        wbWrite, loadUse, branchTaken;

   assign idCtrl  = decodeCtrl(ifId_q.instr);
   assign idRs1   = ifId_q.instr[19:15];
   assign idRs2   = ifId_q.instr[24:20];
   assign wbValue = memWb_q.memToReg ? memWb_q.loadData : memWb_q.aluResult;
   assign wbWrite = memWb_q.regWrite && (memWb_q.rd != 5'd0);

   riscv_regfile u_reg (
      .clk      (clk),
      .rst      (rst),
      .raddrA_i (idRs1),
      .raddrB_i (idRs2),
      .rdataA_o (rs1Val),
      .rdataB_o (rs2Val),
      .we_i     (wbWrite),
      .waddr_i  (memWb_q.rd),
      .wdata_i  (wbValue)
   );

   // Stores are gated during reset so an in-flight SW cannot commit.
   assign dmemBus.wordAddr = exMem_q.aluResult[DMEM_AW+1:2];
   assign dmemBus.wdata    = exMem_q.storeData;
   assign dmemBus.we       = exMem_q.memWrite && !rst;

   riscv_dmem u_dmem (
      .clk (clk),
      .bus (dmemBus.slave)
   );

   // EX/MEM beats MEM/WB; x0 is never forwarded.
   always_comb begin
      fwdA = idEx_q.rs1Val;
      fwdB = idEx_q.rs2Val;
      if (exMem_q.regWrite && exMem_q.rd != 5'd0 && exMem_q.rd == idEx_q.rs1) begin
         fwdA = exMem_q.aluResult;
      end else if (wbWrite && memWb_q.rd == idEx_q.rs1) begin
         fwdA = wbValue;
      end
      if (exMem_q.regWrite && exMem_q.rd != 5'd0 && exMem_q.rd == idEx_q.rs2) begin
         fwdB = exMem_q.aluResult;
      end else if (wbWrite && memWb_q.rd == idEx_q.rs2) begin
         fwdB = wbValue;
      end
   end

   assign aluB        = idEx_q.ctrl.aluSrc ? idEx_q.imm : fwdB;
   assign aluResult   = (idEx_q.aluOp == ALU_ADD) ? fwdA + aluB : '0;
   assign branchTaken = idEx_q.ctrl.branch && (fwdA == fwdB);
   assign loadUse     = idEx_q.ctrl.memRead && (idEx_q.rd != 5'd0) &&
                        (idEx_q.rd == idRs1 || idEx_q.rd == idRs2);

   // A taken branch overrides a simultaneous load-use stall.
   always_comb begin
      pc_d         = pc_q + 32'd4;
      ifId_d.pc    = pc_q;
      ifId_d.instr = rom[pc_q[ROM_AW+1:2]];

      idEx_d.ctrl   = idCtrl;
      idEx_d.aluOp  = (idCtrl.regWrite || idCtrl.memWrite) ? ALU_ADD : ALU_NONE;
      idEx_d.pc     = ifId_q.pc;
      idEx_d.rs1Val = rs1Val;
      idEx_d.rs2Val = rs2Val;
      idEx_d.imm    = immGen(ifId_q.instr);
      idEx_d.rs1    = idRs1;
      idEx_d.rs2    = idRs2;
      idEx_d.rd     = ifId_q.instr[11:7];

      if (branchTaken) begin
         pc_d         = idEx_q.pc + idEx_q.imm;
         ifId_d.pc    = '0;
         ifId_d.instr = NOP_INSTR;
         idEx_d       = '0;
      end else if (loadUse) begin
         pc_d   = pc_q;
         ifId_d = ifId_q;
         idEx_d = '0;
      end
   end

   always_comb begin
      exMem_d.regWrite  = idEx_q.ctrl.regWrite;
      exMem_d.memWrite  = idEx_q.ctrl.memWrite;
      exMem_d.memToReg  = idEx_q.ctrl.memToReg;
      exMem_d.aluResult = aluResult;
      exMem_d.storeData = fwdB;
      exMem_d.rd        = idEx_q.rd;

      memWb_d.regWrite  = exMem_q.regWrite;
      memWb_d.memToReg  = exMem_q.memToReg;
      memWb_d.aluResult = exMem_q.aluResult;
      memWb_d.loadData  = dmemBus.rdata;
      memWb_d.rd        = exMem_q.rd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q         <= '0;
         ifId_q.pc    <= '0;
         ifId_q.instr <= NOP_INSTR;
         idEx_q       <= '0;
         exMem_q      <= '0;
         memWb_q      <= '0;
      end else begin
         pc_q    <= pc_d;
         ifId_q  <= ifId_d;
         idEx_q  <= idEx_d;
         exMem_q <= exMem_d;
         memWb_q <= memWb_d;
      end
   end

endmodule

// File: tb/tb_riscv_pipeline_core.sv
// Self-checking bench: directed hazard/timing scenarios plus random programs
// compared against an instruction-at-a-time architectural model.
module tb_riscv_pipeline_core;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   logic [31:0] prog     [0:255];
   logic [31:0] mMemInit [0:255];
   logic [31:0] mMem     [0:255];
   logic [31:0] mReg     [0:31];
   int          progLen;

   always #5 clk = ~clk;

   riscv_pipeline_core dut (.clk(clk), .rst(rst));

   riscv_pipeline_core_if tbBus ();
   assign tbBus.we       = dut.dmemBus.we;
   assign tbBus.wordAddr = dut.dmemBus.wordAddr;
   assign tbBus.wdata    = dut.dmemBus.wdata;
   assign tbBus.rdata    = dut.dmemBus.rdata;

   function automatic logic [31:0] encI(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [11:0] imm, input logic [2:0] f3,
                                        input logic [6:0] opc);
      return {imm, rs1, f3, rd, opc};
   endfunction

   function automatic logic [31:0] encR(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [6:0] f7);
      return {f7, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction

   function automatic logic [31:0] encS(input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [11:0] imm, input logic [2:0] f3);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] encB(input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [12:0] imm, input logic [2:0] f3);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   task automatic clearProgram();
      for (int i = 0; i < 256; i++) begin
         prog[i]     = 32'h0000_0013;
         mMemInit[i] = 32'h0;
      end
      progLen = 0;
   endtask

   // Reset is held for two edges; ROM and RAM are loaded while it is high.
   task automatic resetCore();
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 256; i++) begin
         dut.rom[i]         = prog[i];
         dut.u_dmem.ram[i]  = mMemInit[i];
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic runEdges(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   // Architectural model: one whole instruction per step, no pipeline notion.
   task automatic runModel();
      logic [31:0] pc, ins, a, b, addr, iImm, sImm, bImm;
      logic [6:0]  opc;
      logic [2:0]  f3;
      for (int i = 0; i < 32; i++) mReg[i] = 32'h0;
      for (int i = 0; i < 256; i++) mMem[i] = mMemInit[i];
      pc = 32'h0;
      for (int step = 0; step < 1000; step++) begin
         if (pc / 4 >= progLen) break;
         ins  = prog[pc / 4];
         opc  = ins[6:0];
         f3   = ins[14:12];
         a    = mReg[ins[19:15]];
         b    = mReg[ins[24:20]];
         iImm = {{20{ins[31]}}, ins[31:20]};
         sImm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
         bImm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
         pc   = pc + 32'd4;
         if (opc == 7'h13 && f3 == 3'd0) begin
            mReg[ins[11:7]] = a + iImm;
         end else if (opc == 7'h33 && f3 == 3'd0 && ins[31:25] == 7'd0) begin
            mReg[ins[11:7]] = a + b;
         end else if (opc == 7'h03 && f3 == 3'd2) begin
            addr = a + iImm;
            mReg[ins[11:7]] = mMem[(addr / 4) % 256];
         end else if (opc == 7'h23 && f3 == 3'd2) begin
            addr = a + sImm;
            mMem[(addr / 4) % 256] = b;
         end else if (opc == 7'h63 && f3 == 3'd0 && a == b) begin
            pc = pc - 32'd4 + bImm;
         end
         mReg[0] = 32'h0;
      end
   endtask

   task automatic setMainProgram();
      clearProgram();
      prog[0] = 32'h0050_0093;
      prog[1] = 32'h0070_0113;
      prog[2] = 32'h0020_81B3;
      prog[3] = 32'h0030_2423;
      prog[4] = 32'h00A0_2203;
      prog[5] = 32'h0031_A463;
      prog[6] = 32'h0630_0293;
      prog[7] = 32'h0370_0293;
      progLen = 8;
      for (int i = 0; i < 256; i++) mMemInit[i] = 32'hDEAD_0000 + i;
   endtask

   task automatic test_main_program();
      logic [31:0] exp [1:5];
      exp[1] = 5; exp[2] = 7; exp[3] = 12; exp[4] = 12; exp[5] = 55;
      setMainProgram();
      resetCore();
      runEdges(60);
      for (int r = 1; r <= 5; r++) begin
         checks++;
         if (dut.u_reg.regs[r] !== exp[r]) begin
            failures++;
            $display("[TB] FAIL main_x%0d: got %0d expected %0d", r, dut.u_reg.regs[r], exp[r]);
         end
      end
      checks++;
      if (dut.u_dmem.ram[2] !== 32'd12) begin
         failures++;
         $display("[TB] FAIL main_ram2: got %h expected %h", dut.u_dmem.ram[2], 32'd12);
      end
   endtask

   task automatic test_reset();
      int nonZero;
      setMainProgram();
      resetCore();
      runEdges(6);
      checks++;
      if (dut.u_reg.regs[2] !== 32'd7) begin
         failures++;
         $display("[TB] FAIL midreset_pre_x2: got %0d expected 7", dut.u_reg.regs[2]);
      end
      rst = 1'b1;
      runEdges(1);
      nonZero = 0;
      for (int r = 0; r < 32; r++) if (dut.u_reg.regs[r] !== 32'h0) nonZero++;
      checks++;
      if (nonZero != 0) begin
         failures++;
         $display("[TB] FAIL midreset_regs: got %0d nonzero regs expected 0", nonZero);
      end
      checks++;
      if (dut.u_dmem.ram[2] !== 32'hDEAD_0002) begin
         failures++;
         $display("[TB] FAIL midreset_no_store: got %h expected %h", dut.u_dmem.ram[2], 32'hDEAD_0002);
      end
      checks++;
      if (dut.pc_q !== 32'h0) begin
         failures++;
         $display("[TB] FAIL midreset_pc: got %h expected 0", dut.pc_q);
      end
      rst = 1'b0;
      runEdges(1);
      checks++;
      if (dut.ifId_q.instr !== 32'h0050_0093) begin
         failures++;
         $display("[TB] FAIL midreset_refetch: got %h expected %h", dut.ifId_q.instr, 32'h0050_0093);
      end
      runEdges(59);
      checks++;
      if (dut.u_reg.regs[5] !== 32'd55 || dut.u_dmem.ram[2] !== 32'd12) begin
         failures++;
         $display("[TB] FAIL midreset_rerun: got x5=%0d ram2=%0d expected 55 12",
                  dut.u_reg.regs[5], dut.u_dmem.ram[2]);
      end
   endtask

   task automatic test_forwarding();
      clearProgram();
      prog[0] = encI(5'd1, 5'd0, 12'd5, 3'd0, 7'h13);
      prog[1] = encR(5'd2, 5'd1, 5'd1, 7'd0);
      progLen = 2;
      resetCore();
      runEdges(5);
      checks++;
      if (dut.u_reg.regs[1] !== 32'd5 || dut.u_reg.regs[2] !== 32'd0) begin
         failures++;
         $display("[TB] FAIL fwd_edge5: got x1=%0d x2=%0d expected 5 0",
                  dut.u_reg.regs[1], dut.u_reg.regs[2]);
      end
      runEdges(1);
      checks++;
      if (dut.u_reg.regs[2] !== 32'd10) begin
         failures++;
         $display("[TB] FAIL fwd_x2: got %0d expected 10", dut.u_reg.regs[2]);
      end
   endtask

   task automatic test_load_use();
      clearProgram();
      prog[0] = encI(5'd1, 5'd0, 12'd12, 3'd0, 7'h13);
      prog[1] = encS(5'd1, 5'd0, 12'd16, 3'd2);
      prog[2] = encI(5'd4, 5'd0, 12'd16, 3'd2, 7'h03);
      prog[3] = encR(5'd5, 5'd4, 5'd4, 7'd0);
      progLen = 4;
      resetCore();
      runEdges(4);
      checks++;
      if (tbBus.we !== 1'b1 || tbBus.wordAddr !== 8'd4 || tbBus.wdata !== 32'd12) begin
         failures++;
         $display("[TB] FAIL lu_store_bus: got we=%b addr=%0d data=%0d expected 1 4 12",
                  tbBus.we, tbBus.wordAddr, tbBus.wdata);
      end
      checks++;
      if (dut.u_dmem.ram[4] !== 32'd0) begin
         failures++;
         $display("[TB] FAIL lu_store_early: got %0d expected 0", dut.u_dmem.ram[4]);
      end
      runEdges(1);
      checks++;
      if (dut.u_dmem.ram[4] !== 32'd12) begin
         failures++;
         $display("[TB] FAIL lu_store_commit: got %0d expected 12", dut.u_dmem.ram[4]);
      end
      runEdges(2);
      checks++;
      if (dut.u_reg.regs[4] !== 32'd12) begin
         failures++;
         $display("[TB] FAIL lu_x4: got %0d expected 12", dut.u_reg.regs[4]);
      end
      runEdges(1);
      checks++;
      if (dut.u_reg.regs[5] !== 32'd0) begin
         failures++;
         $display("[TB] FAIL lu_bubble: got x5=%0d expected 0 before bubbled writeback", dut.u_reg.regs[5]);
      end
      runEdges(1);
      checks++;
      if (dut.u_reg.regs[5] !== 32'd24) begin
         failures++;
         $display("[TB] FAIL lu_x5: got %0d expected 24", dut.u_reg.regs[5]);
      end
   endtask

   task automatic test_branch_flush();
      clearProgram();
      prog[0] = encB(5'd0, 5'd0, 13'd8, 3'd0);
      prog[1] = encI(5'd6, 5'd0, 12'd1, 3'd0, 7'h13);
      prog[2] = encI(5'd7, 5'd0, 12'd3, 3'd0, 7'h13);
      progLen = 3;
      resetCore();
      runEdges(7);
      checks++;
      if (dut.u_reg.regs[7] !== 32'd0) begin
         failures++;
         $display("[TB] FAIL br_flushed_copy: got x7=%0d expected 0", dut.u_reg.regs[7]);
      end
      runEdges(1);
      checks++;
      if (dut.u_reg.regs[7] !== 32'd3) begin
         failures++;
         $display("[TB] FAIL br_target: got x7=%0d expected 3", dut.u_reg.regs[7]);
      end
      runEdges(10);
      checks++;
      if (dut.u_reg.regs[6] !== 32'd0) begin
         failures++;
         $display("[TB] FAIL br_x6: got %0d expected 0", dut.u_reg.regs[6]);
      end
   endtask

   task automatic test_x0_write();
      clearProgram();
      prog[0] = encI(5'd0, 5'd0, 12'd7, 3'd0, 7'h13);
      prog[1] = encI(5'd1, 5'd0, 12'd3, 3'd0, 7'h13);
      progLen = 2;
      resetCore();
      runEdges(10);
      checks++;
      if (dut.u_reg.regs[0] !== 32'd0) begin
         failures++;
         $display("[TB] FAIL x0_reg: got %0d expected 0", dut.u_reg.regs[0]);
      end
      checks++;
      if (dut.u_reg.regs[1] !== 32'd3) begin
         failures++;
         $display("[TB] FAIL x0_no_forward: got x1=%0d expected 3", dut.u_reg.regs[1]);
      end
   endtask

   task automatic test_random();
      logic [4:0]  rd, rs1, rs2;
      logic [11:0] imm;
      int          badRam, firstBad;
      for (int iter = 0; iter < 8; iter++) begin
         clearProgram();
         progLen = 24;
         for (int i = 0; i < 256; i++) mMemInit[i] = $urandom;
         for (int i = 0; i < progLen; i++) begin
            rd  = 5'($urandom_range(0, 7));
            rs1 = 5'($urandom_range(0, 7));
            rs2 = 5'($urandom_range(0, 7));
            imm = 12'($urandom);
            case ($urandom_range(0, 9))
               0, 1, 2: prog[i] = encI(rd, rs1, imm, 3'd0, 7'h13);
               3, 4:    prog[i] = encR(rd, rs1, rs2, 7'd0);
               5, 6:    prog[i] = encI(rd, rs1, imm, 3'd2, 7'h03);
               7:       prog[i] = encS(rs2, rs1, imm, 3'd2);
               8:       prog[i] = encB(5'($urandom_range(0, 2)), 5'($urandom_range(0, 2)),
                                       13'(4 * $urandom_range(1, 6)), 3'd0);
               default: begin
                  case ($urandom_range(0, 4))
                     0:       prog[i] = encR(rd, rs1, rs2, 7'h20);
                     1:       prog[i] = encI(rd, rs1, imm, 3'd1, 7'h13);
                     2:       prog[i] = encI(rd, rs1, imm, 3'd0, 7'h03);
                     3:       prog[i] = encS(rs2, rs1, imm, 3'd0);
                     default: prog[i] = encB(5'd0, 5'd0, 13'd8, 3'd1);
                  endcase
               end
            endcase
         end
         runModel();
         resetCore();
         runEdges(90);
         for (int r = 1; r < 8; r++) begin
            checks++;
            if (dut.u_reg.regs[r] !== mReg[r]) begin
               failures++;
               $display("[TB] FAIL rand%0d_x%0d: got %h expected %h", iter, r, dut.u_reg.regs[r], mReg[r]);
            end
         end
         badRam = 0;
         firstBad = -1;
         for (int i = 0; i < 256; i++) begin
            if (dut.u_dmem.ram[i] !== mMem[i]) begin
               badRam++;
               if (firstBad < 0) firstBad = i;
            end
         end
         checks++;
         if (badRam != 0) begin
            failures++;
            $display("[TB] FAIL rand%0d_ram: got %0d differing words (first at %0d) expected 0",
                     iter, badRam, firstBad);
         end
      end
   endtask

   initial begin
      test_main_program();
      test_reset();
      test_forwarding();
      test_load_use();
      test_branch_flush();
      test_x0_write();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
